// File: rtl/host_cmd_decoder.sv
// Framed host write-command decoder: HEADER, ADDR, data bytes (MSB first), XOR checksum -> register bank.
// Optional ack back-channel enabled by defining HOST_CMD_ACK_EN.
module host_cmd_decoder #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned REG_BYTES  = 1,
  parameter logic [7:0]  HEADER     = 8'hFF,
  parameter int unsigned CLK_FREQ   = 200_000_000,
  parameter int unsigned TIMEOUT_US = 100,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = (NUM_REGS*REG_BYTES*8)'(10)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      data_rx,
  input  logic                            rx_done,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs_flat,
  output logic [NUM_REGS-1:0]             reg_wr_stb,
  output logic                            frame_err,
  output logic [15:0]                     err_cnt,
  output logic                            busy
`ifdef HOST_CMD_ACK_EN
  ,
  output logic [7:0]                      ack_data,
  output logic                            ack_valid,
  input  logic                            ack_ready
`endif
);

  localparam int unsigned RW     = 8 * REG_BYTES;
  localparam int unsigned BANK_W = NUM_REGS * RW;
  localparam int unsigned TO_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
  localparam int unsigned IDX_W  = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_addr;
  logic [7:0]         r_xor;
  logic [RW-1:0]      r_shadow;
  logic [IDX_W-1:0]   r_idx;
  logic [TO_W-1:0]    r_to_cnt;
  logic [BANK_W-1:0]  r_regs;
  logic [NUM_REGS-1:0] r_stb;
  logic               r_err;
  logic [15:0]        r_err_cnt;
  logic               r_busy;
  logic               w_commit;
  logic               w_err;
  logic               w_to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus commit/reject decisions; an arriving byte beats a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_to_hit    = (r_to_cnt == TO_W'(TO_CYC));
    case (r_state)
      S_IDLE: if (rx_done && data_rx == HEADER) w_state_nxt = S_ADDR;
      S_ADDR: if (rx_done) w_state_nxt = S_DATA;
      S_DATA: if (rx_done && r_idx == IDX_W'(REG_BYTES - 1)) w_state_nxt = S_CSUM;
      S_CSUM: begin
        if (rx_done) begin
          w_state_nxt = S_IDLE;
          if (data_rx == r_xor && r_addr < 8'(NUM_REGS)) w_commit = 1'b1;
          else                                           w_err    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE && !rx_done && w_to_hit) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end
  end

  // Frame datapath: address latch, shadow shift, running checksum, inter-byte timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_xor    <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_state == S_IDLE || rx_done) r_to_cnt <= '0;
      else if (!w_to_hit)               r_to_cnt <= r_to_cnt + TO_W'(1);
      if (rx_done && r_state == S_ADDR) begin
        r_addr <= data_rx;
        r_xor  <= data_rx;
        r_idx  <= '0;
      end
      if (rx_done && r_state == S_DATA) begin
        r_shadow <= RW'({r_shadow, data_rx});
        r_xor    <= r_xor ^ data_rx;
        r_idx    <= r_idx + IDX_W'(1);
      end
    end
  end

  // Register bank, write strobes and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs    <= RESET_VALUES;
      r_stb     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_stb  <= '0;
      r_err  <= w_err;
      r_busy <= (w_state_nxt != S_IDLE);
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (w_commit && r_addr == 8'(k)) begin
          r_regs[k*RW +: RW] <= r_shadow;
          r_stb[k]           <= 1'b1;
        end
      end
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign regs_flat  = r_regs;
  assign reg_wr_stb = r_stb;
  assign frame_err  = r_err;
  assign err_cnt    = r_err_cnt;
  assign busy       = r_busy;

`ifdef HOST_CMD_ACK_EN
  logic [7:0] r_ack_data;
  logic       r_ack_valid;

  // A newer ack overwrites a pending one, taking priority over the handshake clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_data  <= '0;
      r_ack_valid <= 1'b0;
    end else if (w_commit || w_err) begin
      r_ack_data  <= w_commit ? 8'hAC : 8'hEC;
      r_ack_valid <= 1'b1;
    end else if (r_ack_valid && ack_ready) begin
      r_ack_valid <= 1'b0;
    end
  end

  assign ack_data  = r_ack_data;
  assign ack_valid = r_ack_valid;
`endif

endmodule
